// File: rtl/step_sequencer_if.sv
// Instruction request and datapath-enable bundle between the issuer and step_sequencer.
// The issuer owns the master side and the sequencer owns the slave side.
interface step_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = 4
);
    logic                start;
    logic [1:0]          op;
    logic [SEL_W-1:0]    rd_sel;
    logic [SEL_W-1:0]    rs_sel;
    logic [NUM_REGS-1:0] reg_out;
    logic [NUM_REGS-1:0] reg_in;
    logic                y_in;
    logic                z_in;
    logic                z_out;
    logic [1:0]          alu_op;
    logic                busy;
    logic                done;

    modport master (
        output start, op, rd_sel, rs_sel,
        input  reg_out, reg_in, y_in, z_in, z_out, alu_op, busy, done
    );

    modport slave (
        input  start, op, rd_sel, rs_sel,
        output reg_out, reg_in, y_in, z_in, z_out, alu_op, busy, done
    );
endinterface

// File: rtl/step_sequencer.sv
// Init/T0..T2 control-step machine that sequences bus, Y and Z enables for one
// MOV/ADD/SUB/AND register instruction; state advances on the falling clock edge.
module step_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = 4
) (
    input  logic              clock,
    input  logic              clear,
    step_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_MOV = 2'b00;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [SEL_W-1:0] rd_q, rd_d;
    logic [SEL_W-1:0] rs_q, rs_d;

    // Out-of-range selects match no bit, giving an all-zero vector.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) begin
            v[i] = (32'(sel) == i);
        end
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_T0;
                    op_d    = bus.op;
                    rd_d    = bus.rd_sel;
                    rs_d    = bus.rs_sel;
                end
            end
            S_T0:    state_d = (op_q == OP_MOV) ? S_DONE : S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Enables decode purely from registered state so they settle before the
    // datapath's rising-edge capture.
    always_comb begin
        bus.reg_out = '0;
        bus.reg_in  = '0;
        bus.y_in    = 1'b0;
        bus.z_in    = 1'b0;
        bus.z_out   = 1'b0;
        bus.alu_op  = (state_q == S_IDLE) ? 2'b00 : op_q;
        bus.busy    = (state_q != S_IDLE);
        bus.done    = 1'b0;
        unique case (state_q)
            S_T0: begin
                if (op_q == OP_MOV) begin
                    bus.reg_out = onehot(rs_q);
                    bus.reg_in  = onehot(rd_q);
                end else begin
                    bus.reg_out = onehot(rd_q);
                    bus.y_in    = 1'b1;
                end
            end
            S_T1: begin
                bus.reg_out = onehot(rs_q);
                bus.z_in    = 1'b1;
            end
            S_T2: begin
                bus.z_out  = 1'b1;
                bus.reg_in = onehot(rd_q);
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(negedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
        end
    end
endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus random instruction streams,
// each checked every cycle against a queue-of-micro-steps reference model.
module tb_step_sequencer;
    localparam int NUM_REGS = 16;
    localparam int SEL_W    = 4;

    typedef struct packed {
        logic [15:0] ro;
        logic [15:0] ri;
        logic        y;
        logic        z;
        logic        zo;
        logic [1:0]  alu;
        logic        busy;
        logic        done;
    } outs_t;

    logic clock = 1'b0;
    logic clear;
    int   errors = 0;
    int   checks = 0;
    outs_t q[$];

    step_sequencer_if #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) ifc ();

    step_sequencer #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (ifc.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] oh(input logic [3:0] s);
        return (int'(s) < NUM_REGS) ? (16'h1 << s) : 16'h0;
    endfunction

    // An accepted instruction expands into its list of per-cycle output records.
    function automatic void launch(input logic [1:0] o, input logic [3:0] d, input logic [3:0] s);
        outs_t r;
        r = '0; r.alu = o; r.busy = 1'b1;
        if (o == 2'b00) begin
            r.ro = oh(s); r.ri = oh(d); q.push_back(r);
        end else begin
            r.ro = oh(d); r.y = 1'b1; q.push_back(r);
            r = '0; r.alu = o; r.busy = 1'b1;
            r.ro = oh(s); r.z = 1'b1; q.push_back(r);
            r = '0; r.alu = o; r.busy = 1'b1;
            r.zo = 1'b1; r.ri = oh(d); q.push_back(r);
        end
        r = '0; r.alu = o; r.busy = 1'b1; r.done = 1'b1;
        q.push_back(r);
    endfunction

    function automatic void model_edge();
        outs_t dummy;
        if (!clear) begin
            q.delete();
        end else if (q.size() > 0) begin
            dummy = q.pop_front();
        end else if (ifc.start) begin
            launch(ifc.op, ifc.rd_sel, ifc.rs_sel);
        end
    endfunction

    function automatic outs_t exp_now();
        return (q.size() > 0) ? q[0] : outs_t'('0);
    endfunction

    function automatic outs_t act();
        outs_t r;
        r.ro = ifc.reg_out; r.ri = ifc.reg_in;
        r.y = ifc.y_in; r.z = ifc.z_in; r.zo = ifc.z_out;
        r.alu = ifc.alu_op; r.busy = ifc.busy; r.done = ifc.done;
        return r;
    endfunction

    // Inputs change after the rising edge; state moves on the falling edge; outputs read on the rising edge.
    task automatic step();
        @(negedge clock);
        model_edge();
        @(posedge clock);
    endtask

    task automatic drive(input logic st, input logic [1:0] o, input logic [3:0] d, input logic [3:0] s);
        ifc.start  = st;
        ifc.op     = o;
        ifc.rd_sel = d;
        ifc.rs_sel = s;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        drive(1'b1, 2'b00, 4'd3, 4'd5);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (act() !== outs_t'('0)) begin
                errors++;
                $display("FAIL reset_hold: got %h expected %h", act(), outs_t'('0));
            end
        end
        #1 clear = 1'b1;
        step();
        checks++;
        if (ifc.reg_out !== 16'h0020 || ifc.reg_in !== 16'h0008) begin
            errors++;
            $display("FAIL reset_first_accept: got out=%h in=%h expected out=0020 in=0008", ifc.reg_out, ifc.reg_in);
        end
        ifc.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (act() !== exp_now()) begin
                errors++;
                $display("FAIL reset_drain: got %h expected %h", act(), exp_now());
            end
        end
    endtask

    task automatic test_mov();
        int busy_cnt = 0;
        drive(1'b1, 2'b00, 4'd3, 4'd5);
        step();
        ifc.start = 1'b0;
        checks++;
        if (ifc.reg_out !== 16'h0020 || ifc.reg_in !== 16'h0008 || ifc.y_in !== 1'b0) begin
            errors++;
            $display("FAIL mov_t0: got out=%h in=%h y=%b expected out=0020 in=0008 y=0", ifc.reg_out, ifc.reg_in, ifc.y_in);
        end
        if (ifc.busy) busy_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ifc.busy) busy_cnt++;
            checks++;
            if (act() !== exp_now()) begin
                errors++;
                $display("FAIL mov_seq: got %h expected %h", act(), exp_now());
            end
        end
        checks++;
        if (busy_cnt != 2) begin
            errors++;
            $display("FAIL mov_busy_len: got %0d expected 2", busy_cnt);
        end
    endtask

    task automatic test_add();
        drive(1'b1, 2'b01, 4'd1, 4'd2);
        step();
        ifc.start = 1'b0;
        checks++;
        if (ifc.reg_out !== 16'h0002 || ifc.y_in !== 1'b1) begin
            errors++;
            $display("FAIL add_t0: got out=%h y=%b expected out=0002 y=1", ifc.reg_out, ifc.y_in);
        end
        step();
        checks++;
        if (ifc.reg_out !== 16'h0004 || ifc.z_in !== 1'b1 || ifc.alu_op !== 2'b01) begin
            errors++;
            $display("FAIL add_t1: got out=%h z=%b alu=%b expected out=0004 z=1 alu=01", ifc.reg_out, ifc.z_in, ifc.alu_op);
        end
        step();
        checks++;
        if (ifc.z_out !== 1'b1 || ifc.reg_in !== 16'h0002 || ifc.reg_out !== 16'h0000) begin
            errors++;
            $display("FAIL add_t2: got zo=%b in=%h out=%h expected zo=1 in=0002 out=0000", ifc.z_out, ifc.reg_in, ifc.reg_out);
        end
        step();
        checks++;
        if (ifc.done !== 1'b1 || act() !== exp_now()) begin
            errors++;
            $display("FAIL add_done: got %h expected %h", act(), exp_now());
        end
        step();
    endtask

    task automatic test_sub_same_reg();
        drive(1'b1, 2'b10, 4'd7, 4'd7);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) ifc.start = 1'b0;
            checks++;
            if (act() !== exp_now()) begin
                errors++;
                $display("FAIL sub_r7_seq%0d: got %h expected %h", i, act(), exp_now());
            end
            if (i == 1) begin
                checks++;
                if (ifc.reg_out !== 16'h0080 || ifc.alu_op !== 2'b10) begin
                    errors++;
                    $display("FAIL sub_r7_t1: got out=%h alu=%b expected out=0080 alu=10", ifc.reg_out, ifc.alu_op);
                end
                ifc.op = 2'b11; ifc.rs_sel = 4'd3; ifc.rd_sel = 4'd9;
            end
            if (i == 2) begin
                checks++;
                if (ifc.reg_in !== 16'h0080 || ifc.alu_op !== 2'b10) begin
                    errors++;
                    $display("FAIL sub_r7_t2: got in=%h alu=%b expected in=0080 alu=10", ifc.reg_in, ifc.alu_op);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int done_cnt = 0;
        drive(1'b1, 2'b11, 4'd4, 4'd6);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) ifc.start = 1'b0;
            if (i == 1) drive(1'b1, 2'b00, 4'd8, 4'd9);
            if (i == 2) ifc.start = 1'b0;
            if (ifc.done) done_cnt++;
            checks++;
            if (act() !== exp_now()) begin
                errors++;
                $display("FAIL busy_ignore_seq%0d: got %h expected %h", i, act(), exp_now());
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL busy_ignore_done_cnt: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        drive(1'b1, 2'b01, 4'd1, 4'd2);
        step();
        ifc.start = 1'b0;
        step();
        checks++;
        if (ifc.z_in !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got z_in=%b expected 1", ifc.z_in);
        end
        #2 clear = 1'b0;
        q.delete();
        #1;
        checks++;
        if (ifc.z_in !== 1'b0 || ifc.reg_out !== 16'h0 || ifc.busy !== 1'b0 || act() !== outs_t'('0)) begin
            errors++;
            $display("FAIL midrst_drop: got %h expected %h", act(), outs_t'('0));
        end
        for (int i = 0; i < 2; i++) begin
            step();
            if (ifc.done) done_cnt++;
        end
        #1 clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ifc.done) done_cnt++;
            checks++;
            if (act() !== exp_now() || ifc.busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_idle: got %h expected %h", act(), exp_now());
            end
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL midrst_no_done: got %0d expected 0", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        drive(1'b1, 2'b00, 4'd2, 4'd4);
        for (int i = 0; i < 13; i++) begin
            step();
            if (i == 8) ifc.start = 1'b0;
            if (ifc.done) done_cnt++;
            checks++;
            if (act() !== exp_now()) begin
                errors++;
                $display("FAIL b2b_seq%0d: got %h expected %h", i, act(), exp_now());
            end
        end
        checks++;
        if (done_cnt != 3) begin
            errors++;
            $display("FAIL b2b_done_cnt: got %0d expected 3", done_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) == 0, 2'($urandom), 4'($urandom), 4'($urandom));
            step();
            checks++;
            if (act() !== exp_now()) begin
                errors++;
                $display("FAIL rand_seq%0d: got %h expected %h", i, act(), exp_now());
            end
        end
        ifc.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (act() !== exp_now()) begin
                errors++;
                $display("FAIL rand_drain%0d: got %h expected %h", i, act(), exp_now());
            end
        end
    endtask

    initial begin
        test_reset();
        test_mov();
        test_add();
        test_sub_same_reg();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/step_sequencer.md
# step_sequencer

Control-step sequencer that drives the register/bus datapath's enable signals for one register-transfer or ALU instruction at a time. It sits directly upstream of the datapath, replacing hand-sequenced enables with an init/T0..T2 step machine. Each instruction is latched on `start`. The sequencer then asserts the out/in/Yin/Zin enables that move operands across the shared bus through Y and Z, and reports completion with `done`.

## Interface
- `NUM_REGS`, 16: number of general registers; width of the one-hot `reg_out`/`reg_in` vectors.
- `SEL_W`, 4: width of the register selects; must satisfy 2^SEL_W ≥ NUM_REGS.
- `clock`  in  1  system clock. All state updates on the falling edge.
- `clear`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to execute one instruction; sampled only in IDLE.
- `op`  in  2  instruction: 00 MOV (Rd←Rs), 01 ADD (Rd←Rd+Rs), 10 SUB (Rd←Rd−Rs), 11 AND (Rd←Rd&Rs).
- `rd_sel`  in  SEL_W  destination (and first operand) register index.
- `rs_sel`  in  SEL_W  source register index.
- `reg_out`  out  NUM_REGS  one-hot register-to-bus drive enables.
- `reg_in`  out  NUM_REGS  one-hot bus-to-register load enables.
- `y_in`  out  1  load the Y operand register from the bus.
- `z_in`  out  1  load Z from the ALU result.
- `z_out`  out  1  drive Z onto the bus.
- `alu_op`  out  2  ALU function. Equals the latched `op` outside IDLE; 00 in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in DONE.

## Operation
- A "cycle" runs from one falling edge to the next. The state register and the instruction latch (op, rd, rs) update on the falling edge.
- Outputs decode only from the state register and the latch, with no combinational path from the inputs. They therefore settle half a period before the datapath's rising-edge capture.
- States are IDLE, T0, T1, T2 and DONE.
- IDLE: all enables are 0. If `start`=1, latch `op`/`rd_sel`/`rs_sel` and go to T0. Otherwise stay in IDLE.
- MOV, T0: `reg_out[rs]`=1 and `reg_in[rd]`=1. Next state is DONE.
- ALU op, T0: `reg_out[rd]`=1 and `y_in`=1. Next state is T1.
- ALU op, T1: `reg_out[rs]`=1 and `z_in`=1. Next state is T2.
- ALU op, T2: `z_out`=1 and `reg_in[rd]`=1. Next state is DONE.
- DONE: all enables are 0 and `done`=1. Next state is always IDLE.
- At most one bit of `reg_out` and at most one bit of `reg_in` is high in any cycle.
- `reg_out` and `z_out` are never high together, so the bus has a single driver.
- A select ≥ NUM_REGS produces all-zero `reg_out`/`reg_in` for that index. The sequence still runs and `done` still pulses.
- `rd_sel` = `rs_sel` is legal (e.g. ADD R2,R2 doubles R2). The enable pattern is unchanged.
- Changes on `op`/`rd_sel`/`rs_sel` after the latching edge have no effect on the instruction in flight.

## Timing
- Reset (`clear`=0, asynchronous): state goes to IDLE and the latch clears to 0 immediately.
- Reset values: `reg_out`=0, `reg_in`=0, `y_in`=`z_in`=`z_out`=0, `alu_op`=00, `busy`=0, `done`=0.
- Reset mid-instruction: outputs drop within the same cycle and the instruction is abandoned without a `done` pulse.
- Coming out of reset, the first falling edge with `clear`=1 samples `start`.
- MOV latency: 2 cycles from the accepting edge to `done` (T0, DONE). The next start is accepted on the edge after DONE, giving 3 cycles per instruction.
- ALU latency: 4 cycles (T0, T1, T2, DONE), giving 5 cycles per instruction.
- `start` while `busy`=1 is ignored and not queued.
- `start` held high continuously re-launches on every return to IDLE.

## Test plan
- Reset: hold `clear`=0 for 3 cycles with `start`=1, then release.
  - While `clear`=0, all outputs stay 0.
  - The first post-reset falling edge accepts the instruction.
- MOV R3←R5 (`op`=00, `rd_sel`=3, `rs_sel`=5) with a 1-cycle `start`.
  - T0: `reg_out`=16'h0020 and `reg_in`=16'h0008.
  - Next cycle: `done`=1.
  - `busy` is high for exactly 2 cycles.
- ADD R1,R2 (`op`=01).
  - T0: `reg_out`=16'h0002, `y_in`=1.
  - T1: `reg_out`=16'h0004, `z_in`=1, `alu_op`=01.
  - T2: `z_out`=1, `reg_in`=16'h0002.
  - DONE pulse in the 4th cycle.
- SUB R7,R7: T0 and T1 both drive `reg_out`=16'h0080, and T2 loads `reg_in`=16'h0080.
  - Change `op`/`rs_sel` during T1; the enables must not change.
- Pulse `start` with a new instruction during T1 of an AND: it is ignored, and only one `done` is seen.
- Assert `clear`=0 in the middle of T1 of an ADD.
  - `z_in`, `reg_out` and `busy` drop immediately and no `done` occurs.
  - The state reads IDLE after release.
